// File: rtl/ffs_rr_arbiter_if.sv
// Handshake bundle between N requesters / one downstream resource and the
// round-robin arbiter.
//
// Handshake: the arbiter raises grant_valid with a stable one-hot grant and
// grant_idx; the resource raises out_ready when it takes the grant. A beat
// transfers on every posedge where grant_valid & out_ready are both 1. While
// grant_valid=1 and out_ready=0 the grant is held unchanged. out_ready is
// ignored while grant_valid=0.
//
// The master modport is the requester/resource side; the slave modport is the
// arbiter.
interface ffs_rr_arbiter_if #(
  parameter int N     = 16,
  parameter int IDX_W = 4
);
  logic [N-1:0]     req;
  logic [N-1:0]     lock;
  logic             out_ready;
  logic             grant_valid;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] ptr_dbg;
  logic             state_dbg;

  modport master (
    output req,
    output lock,
    output out_ready,
    input  grant_valid,
    input  grant,
    input  grant_idx,
    input  ptr_dbg,
    input  state_dbg
  );

  modport slave (
    input  req,
    input  lock,
    input  out_ready,
    output grant_valid,
    output grant,
    output grant_idx,
    output ptr_dbg,
    output state_dbg
  );
endinterface

// File: rtl/ffs_rr_arbiter.sv
// Round-robin arbiter for N requesters sharing one downstream resource.
// The winner is the lowest set request bit at or above a rotating pointer,
// wrapping to the lowest set bit overall. The one-hot grant and its index are
// registered and held until the resource accepts them.
//
// Optional feature macro: ARB_LOCK_EN. When defined, a requester holding its
// lock bit keeps the grant for up to LOCK_MAX consecutive beats. When
// undefined, the lock input is ignored and no lock counter exists.
module ffs_rr_arbiter #(
  parameter int N        = 16,
  parameter int IDX_W    = $clog2(N),
  parameter int LOCK_MAX = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  ffs_rr_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Result of a search: hit flag in the MSB, winning index below it.
  typedef struct packed {
    logic             hit;
    logic [IDX_W-1:0] idx;
  } pick_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     grant_q, grant_d;

  logic [IDX_W-1:0] adv_ptr;
  logic [IDX_W-1:0] search_ptr;
  pick_t            win;
  logic             handshake;
  logic             hold_owner;

  // Lowest set bit of r at or above p; if none, lowest set bit of r overall.
  // The descending scan lets the last match (the lowest index) win.
  function automatic pick_t pick(input logic [N-1:0] r,
                                 input logic [IDX_W-1:0] p);
    pick_t            res;
    logic             hit_m;
    logic             hit_r;
    logic [IDX_W-1:0] idx_m;
    logic [IDX_W-1:0] idx_r;
    hit_m = 1'b0;
    hit_r = 1'b0;
    idx_m = '0;
    idx_r = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (r[i]) begin
        hit_r = 1'b1;
        idx_r = IDX_W'(i);
        if (IDX_W'(i) >= p) begin
          hit_m = 1'b1;
          idx_m = IDX_W'(i);
        end
      end
    end
    res.hit = hit_r;
    res.idx = hit_m ? idx_m : idx_r;
    return res;
  endfunction

  // Pointer position just past the current owner, wrapping at N-1.
  assign adv_ptr    = (idx_q == IDX_W'(N - 1)) ? '0 : idx_q + IDX_W'(1);
  // From IDLE the search starts at the stored pointer; on a handshake it
  // starts just past the owner that was accepted.
  assign search_ptr = (state_q == GRANT) ? adv_ptr : ptr_q;
  assign win        = pick(bus.req, search_ptr);
  assign handshake  = (state_q == GRANT) && bus.out_ready;

`ifdef ARB_LOCK_EN
  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;

  logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;

  // The owner keeps the resource while it locks, still requests, and has
  // not yet used up its LOCK_MAX consecutive beats.
  assign hold_owner = bus.lock[idx_q] && bus.req[idx_q] &&
                      (lock_cnt_q < CNT_W'(LOCK_MAX - 1));

  // Lock counter: counts re-grants to the same owner, cleared otherwise.
  always_comb begin
    lock_cnt_d = lock_cnt_q;
    if (state_q == IDLE) begin
      lock_cnt_d = '0;
    end else if (handshake) begin
      lock_cnt_d = hold_owner ? lock_cnt_q + CNT_W'(1) : '0;
    end
  end

  // Lock counter register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
    end
  end
`else
  logic lock_unused;

  assign hold_owner  = 1'b0;
  assign lock_unused = |bus.lock;
`endif

  // Next-state logic: arbitrate from IDLE, hold while stalled, re-arbitrate
  // on each handshake so a new grant can follow every cycle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win.hit) begin
          state_d = GRANT;
          idx_d   = win.idx;
        end
      end
      GRANT: begin
        if (handshake) begin
          if (hold_owner) begin
            idx_d = idx_q;
          end else begin
            ptr_d = adv_ptr;
            if (win.hit) begin
              idx_d = win.idx;
            end else begin
              state_d = IDLE;
              idx_d   = '0;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // One-hot grant follows the next index, and is zero whenever idle.
  always_comb begin
    grant_d = '0;
    if (state_d == GRANT) begin
      grant_d[idx_d] = 1'b1;
    end
  end

  // State, index, pointer and grant registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  assign bus.grant_valid = (state_q == GRANT);
  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.ptr_dbg     = ptr_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_ffs_rr_arbiter.sv
// Directed bench for ffs_rr_arbiter: reset hold, rotation, wrap, stall,
// optional lock (ARB_LOCK_EN), reset mid-operation. Accepted beats are
// checked against an expected-index queue.
module tb_ffs_rr_arbiter;
  localparam int N        = 16;
  localparam int IDX_W    = 4;
  localparam int LOCK_MAX = 4;

  logic clk;
  logic reset_n;

  int vectors;
  int miscompares;

  logic [IDX_W-1:0] exp_q[$];

  ffs_rr_arbiter_if #(.N(N), .IDX_W(IDX_W)) bus ();

  ffs_rr_arbiter #(.N(N), .IDX_W(IDX_W), .LOCK_MAX(LOCK_MAX)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, time=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // Driver helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_grant(input string tag, input logic v,
                             input logic [IDX_W-1:0] idx);
    logic [N-1:0] oh;
    oh = '0;
    if (v) oh[idx] = 1'b1;
    check({tag, "_valid"}, 64'(bus.grant_valid), 64'(v));
    check({tag, "_idx"},   64'(bus.grant_idx),   64'(v ? idx : '0));
    check({tag, "_grant"}, 64'(bus.grant),       64'(oh));
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.req       = '0;
    bus.lock      = '0;
    bus.out_ready = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  // Scoreboard: pop one expected index for each accepted beat. The cycle
  // budget is exact, so any idle gap leaves beats unseen.
  task automatic drain(input string tag, input int n, input int budget);
    int               seen;
    int               cyc;
    logic [IDX_W-1:0] e;
    logic [N-1:0]     oh;
    seen = 0;
    cyc  = 0;
    while (seen < n && cyc < budget) begin
      if (bus.grant_valid && bus.out_ready) begin
        e  = exp_q.pop_front();
        oh = '0;
        oh[e] = 1'b1;
        check({tag, "_beat_idx"},   64'(bus.grant_idx), 64'(e));
        check({tag, "_beat_grant"}, 64'(bus.grant),     64'(oh));
        seen++;
      end
      step();
      cyc++;
    end
    check({tag, "_beat_count"}, 64'(seen), 64'(n));
    exp_q.delete();
  endtask

  // Directed sequence
  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset_n       = 1'b0;
    bus.req       = 16'hFFFF;
    bus.lock      = '0;
    bus.out_ready = 1'b0;

    // 1: reset hold with all requesting, then first grant on idx 0
    for (int i = 0; i < 4; i++) begin
      step();
      check_grant("rst_hold", 1'b0, '0);
    end
    check("rst_ptr", 64'(bus.ptr_dbg), 64'd0);
    check("rst_state", 64'(bus.state_dbg), 64'd0);
    reset_n = 1'b1;
    step();
    check_grant("rst_release", 1'b1, 4'd0);
    check("rst_release_state", 64'(bus.state_dbg), 64'd1);

    // out_ready while idle is ignored
    do_reset();
    bus.out_ready = 1'b1;
    step();
    step();
    check_grant("idle_ready", 1'b0, '0);
    check("idle_ready_ptr", 64'(bus.ptr_dbg), 64'd0);

    // 2: rotation between idx 0 and 4, one beat per cycle
    do_reset();
    bus.req       = 16'h0011;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 4'd0 : 4'd4);
    drain("rotate", 8, 9);

    // 3: wrap from idx 14 through 15 to 0
    do_reset();
    bus.req = 16'h4000;
    step();
    check_grant("wrap_14", 1'b1, 4'd14);
    check("wrap_ptr0", 64'(bus.ptr_dbg), 64'd0);
    bus.req       = 16'h8001;
    bus.out_ready = 1'b1;
    step();
    check_grant("wrap_15", 1'b1, 4'd15);
    check("wrap_ptr15", 64'(bus.ptr_dbg), 64'd15);
    step();
    check_grant("wrap_0", 1'b1, 4'd0);
    check("wrap_ptr_back", 64'(bus.ptr_dbg), 64'd0);

    // 4: stall on idx 3; req[1] rises, req[3] drops; no preemption
    do_reset();
    bus.req = 16'h0008;
    step();
    check_grant("stall_first", 1'b1, 4'd3);
    for (int i = 0; i < 5; i++) begin
      bus.req = (i < 2) ? 16'h000A : 16'h0002;
      step();
      check_grant("stall_hold", 1'b1, 4'd3);
      check("stall_ptr", 64'(bus.ptr_dbg), 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    check_grant("stall_next", 1'b1, 4'd1);
    check("stall_ptr_adv", 64'(bus.ptr_dbg), 64'd4);

    // 5: lock on requester 0
    do_reset();
    bus.req       = 16'h0003;
    bus.lock      = 16'h0001;
    bus.out_ready = 1'b1;
`ifdef ARB_LOCK_EN
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 5 == 4) ? 4'd1 : 4'd0);
`else
    for (int i = 0; i < 10; i++) exp_q.push_back((i % 2 == 0) ? 4'd0 : 4'd1);
`endif
    drain("lock", 10, 11);

    // 6: reset while a grant is stalled; the dropped grant does not advance ptr
    do_reset();
    bus.req = 16'h0020;
    step();
    check_grant("midrst_pre", 1'b1, 4'd5);
    reset_n       = 1'b0;
    bus.req       = 16'h0041;
    bus.out_ready = 1'b1;
    step();
    check_grant("midrst_in", 1'b0, '0);
    check("midrst_ptr", 64'(bus.ptr_dbg), 64'd0);
    reset_n       = 1'b1;
    bus.out_ready = 1'b0;
    step();
    check_grant("midrst_after", 1'b1, 4'd0);
    check("midrst_ptr_after", 64'(bus.ptr_dbg), 64'd0);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
